// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cmp_pkg
//  Purpose  : Shared types and constants for the sequential magnitude
//             comparator: FSM state encoding and the one-hot result codes
//             carried on {gt, eq, lt}.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Result encoding, bit order {gt, eq, lt}
    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;
    localparam logic [2:0] RES_NONE = 3'b000;

endpackage : cmp_pkg
`default_nettype wire

// File: rtl/slice_comparator.sv
`default_nettype none
// ============================================================================
//  Module   : slice_comparator
//  Purpose  : Combinational unsigned magnitude compare of one SLICE-bit slice.
//             Exactly one of gt/eq/lt is high for any input pair.
//  Ports    : a, b  [SLICE-1:0]  slice operands
//             gt, eq, lt         a>b, a==b, a<b
//  Revision : 1.0 - initial release
// ============================================================================
module slice_comparator #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);

endmodule : slice_comparator
`default_nettype wire

// File: rtl/seq_magnitude_comparator.sv
`default_nettype none
// ============================================================================
//  Module   : seq_magnitude_comparator
//  Purpose  : Multi-cycle WIDTH-bit magnitude comparator. Operands are latched
//             on accept and compared SLICE bits per cycle, most significant
//             slice first. Unsigned or two's-complement compare is chosen per
//             transaction. Result is one-hot {gt, eq, lt} behind valid/ready.
//  Ports    : clk, rst_n (async active-low)
//             in_valid / in_ready, a, b, is_signed   - operand channel
//             out_valid / out_ready, gt, eq, lt      - result channel
//  Config   : CMP_EARLY_EXIT_EN - when defined, RUN ends on the first slice
//             that differs; otherwise every compare takes NSLICE RUN cycles
//             (constant time, independent of data).
//  Params   : WIDTH must be a multiple of SLICE and >= SLICE.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [IDX_W-1:0]  r_idx;
    logic [2:0]        r_res;

    logic [SLICE-1:0]  w_slice_a;
    logic [SLICE-1:0]  w_slice_b;
    logic              w_slice_gt;
    logic              w_slice_eq;
    logic              w_slice_lt;
    logic [WIDTH-1:0]  w_sign_flip;

    // Flipping the MSB of both operands maps two's-complement order onto
    // unsigned order, so the slice compare never needs to know the mode.
    assign w_sign_flip = is_signed ? MSB_MASK : '0;

    // Slice select: one comparator shared across all slices.
    always_comb begin
        w_slice_a = '0;
        w_slice_b = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_slice_a = r_a[i*SLICE +: SLICE];
                w_slice_b = r_b[i*SLICE +: SLICE];
            end
        end
    end

    slice_comparator #(
        .SLICE (SLICE)
    ) u_slice_cmp (
        .a  (w_slice_a),
        .b  (w_slice_b),
        .gt (w_slice_gt),
        .eq (w_slice_eq),
        .lt (w_slice_lt)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        {gt, eq, lt} = RES_NONE;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
`ifdef CMP_EARLY_EXIT_EN
                // The first differing slice settles the answer; stop there.
                if ((r_idx == '0) || !w_slice_eq) begin
                    w_state_next = DONE;
                end
`else
                if (r_idx == '0) begin
                    w_state_next = DONE;
                end
`endif
            end
            DONE: begin
                out_valid    = 1'b1;
                {gt, eq, lt} = r_res;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand registers, slice index and sticky result.
    // r_res starts at RES_EQ on accept; while it still reads EQ no slice
    // has differed yet, so it doubles as the "decided" flag.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_idx <= IDX_LAST;
            r_res <= RES_NONE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a   <= a ^ w_sign_flip;
                        r_b   <= b ^ w_sign_flip;
                        r_idx <= IDX_LAST;
                        r_res <= RES_EQ;
                    end
                end
                RUN: begin
                    if ((r_res == RES_EQ) && !w_slice_eq) begin
                        r_res <= {w_slice_gt, w_slice_eq, w_slice_lt};
                    end
                    if (r_idx != '0) begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_res <= RES_NONE;
                        r_idx <= IDX_LAST;
                    end
                end
                default: begin
                    r_res <= RES_NONE;
                    r_idx <= IDX_LAST;
                end
            endcase
        end
    end

endmodule : seq_magnitude_comparator
`default_nettype wire

// File: tb/tb_seq_magnitude_comparator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_magnitude_comparator
//  Purpose  : Self-checking bench for seq_magnitude_comparator. Three
//             instances: 16/4 (main), 4/1 and 8/8. Expected results come from
//             integer compares of the operands; expected latency from the
//             position of the highest differing bit (CMP_EARLY_EXIT_EN build)
//             or the slice count.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_magnitude_comparator;

    localparam int TMO = 20;
`ifdef CMP_EARLY_EXIT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 4;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        d16_in_valid, d16_in_ready, d16_is_signed, d16_out_valid, d16_out_ready;
    logic        d16_gt, d16_eq, d16_lt;
    logic [15:0] d16_a, d16_b;
    logic        d4_in_valid, d4_in_ready, d4_is_signed, d4_out_valid, d4_out_ready;
    logic        d4_gt, d4_eq, d4_lt;
    logic [3:0]  d4_a, d4_b;
    logic        d8_in_valid, d8_in_ready, d8_is_signed, d8_out_valid, d8_out_ready;
    logic        d8_gt, d8_eq, d8_lt;
    logic [7:0]  d8_a, d8_b;

    int checks = 0;
    int errors = 0;

    seq_magnitude_comparator #(.WIDTH(16), .SLICE(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(d16_in_valid), .in_ready(d16_in_ready),
        .a(d16_a), .b(d16_b), .is_signed(d16_is_signed), .out_valid(d16_out_valid),
        .out_ready(d16_out_ready), .gt(d16_gt), .eq(d16_eq), .lt(d16_lt));

    seq_magnitude_comparator #(.WIDTH(4), .SLICE(1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(d4_in_valid), .in_ready(d4_in_ready),
        .a(d4_a), .b(d4_b), .is_signed(d4_is_signed), .out_valid(d4_out_valid),
        .out_ready(d4_out_ready), .gt(d4_gt), .eq(d4_eq), .lt(d4_lt));

    seq_magnitude_comparator #(.WIDTH(8), .SLICE(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(d8_in_valid), .in_ready(d8_in_ready),
        .a(d8_a), .b(d8_b), .is_signed(d8_is_signed), .out_valid(d8_out_valid),
        .out_ready(d8_out_ready), .gt(d8_gt), .eq(d8_eq), .lt(d8_lt));

    // ---------------- reference model ----------------
    function automatic logic [2:0] ref_cmp(input int w, input longint ua, input longint ub,
                                           input bit sgn);
        longint va = ua;
        longint vb = ub;
        if (sgn && ua[w-1]) va = ua - (longint'(1) << w);
        if (sgn && ub[w-1]) vb = ub - (longint'(1) << w);
        if (va > vb)  return 3'b100;
        if (va == vb) return 3'b010;
        return 3'b001;
    endfunction

    function automatic int ref_lat(input int w, input int sl, input longint ua, input longint ub);
        int nsl = w / sl;
`ifdef CMP_EARLY_EXIT_EN
        if (ua != ub) begin
            longint d = ua ^ ub;
            int top = 0;
            for (int i = 0; i < w; i++) if (d[i]) top = i;
            return nsl - top / sl;
        end
`endif
        return nsl;
    endfunction

    // ---------------- drivers (called at #1 after a posedge, DUT idle) ----------------
    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s,
                         output logic [2:0] res, output int lat);
        d16_a = a; d16_b = b; d16_is_signed = s; d16_in_valid = 1'b1;
        @(posedge clk); #1;
        d16_in_valid = 1'b0;
        d16_a = 16'($urandom); d16_b = 16'($urandom); d16_is_signed = 1'($urandom);
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!d16_out_valid && lat < TMO);
        res = {d16_gt, d16_eq, d16_lt};
        if (!d16_out_valid) lat = -1;
        d16_out_ready = 1'b1;
        @(posedge clk); #1;
        d16_out_ready = 1'b0;
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s,
                        output logic [2:0] res, output int lat);
        d4_a = a; d4_b = b; d4_is_signed = s; d4_in_valid = 1'b1;
        @(posedge clk); #1;
        d4_in_valid = 1'b0;
        d4_a = 4'($urandom); d4_b = 4'($urandom);
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!d4_out_valid && lat < TMO);
        res = {d4_gt, d4_eq, d4_lt};
        if (!d4_out_valid) lat = -1;
        d4_out_ready = 1'b1;
        @(posedge clk); #1;
        d4_out_ready = 1'b0;
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output logic [2:0] res, output int lat);
        d8_a = a; d8_b = b; d8_is_signed = s; d8_in_valid = 1'b1;
        @(posedge clk); #1;
        d8_in_valid = 1'b0;
        d8_a = 8'($urandom); d8_b = 8'($urandom);
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!d8_out_valid && lat < TMO);
        res = {d8_gt, d8_eq, d8_lt};
        if (!d8_out_valid) lat = -1;
        d8_out_ready = 1'b1;
        @(posedge clk); #1;
        d8_out_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (d16_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", d16_in_ready); end
        checks++; if (d16_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", d16_out_valid); end
        checks++; if ({d16_gt, d16_eq, d16_lt} !== 3'b000) begin errors++; $display("FAIL reset_result got %b exp 000", {d16_gt, d16_eq, d16_lt}); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (d16_in_ready !== 1'b1 || d16_out_valid !== 1'b0) begin errors++; $display("FAIL reset_release got rdy=%b vld=%b exp rdy=1 vld=0", d16_in_ready, d16_out_valid); end
    endtask

    task automatic test_directed();
        logic [15:0] ta [5] = '{16'h1234, 16'h8000, 16'h8000, 16'hA000, 16'h00F1};
        logic [15:0] tb [5] = '{16'h1234, 16'h7FFF, 16'h7FFF, 16'h5000, 16'h00F2};
        logic        ts [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  tr [5] = '{3'b010, 3'b100, 3'b001, 3'b100, 3'b001};
        int          tl [5] = '{4, EARLY_LAT, EARLY_LAT, EARLY_LAT, 4};
        logic [2:0] res;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run16(ta[i], tb[i], ts[i], res, lat);
            checks++; if (res !== tr[i]) begin errors++; $display("FAIL directed_result[%0d] got %b exp %b", i, res, tr[i]); end
            checks++; if (lat !== tl[i]) begin errors++; $display("FAIL directed_latency[%0d] got %0d exp %0d", i, lat, tl[i]); end
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        bit seen = 0;
        d16_a = 16'h0010; d16_b = 16'h0001; d16_is_signed = 1'b0; d16_in_valid = 1'b1;
        @(posedge clk); #1;
        d16_in_valid = 1'b0;
        while (!d16_out_valid && n < TMO) begin @(posedge clk); #1; n++; end
        checks++; if (!d16_out_valid) begin errors++; $display("FAIL bp_wait got out_valid=0 exp 1 within %0d cycles", TMO); end
        for (int c = 0; c < 3; c++) begin
            checks++; if (d16_out_valid !== 1'b1 || {d16_gt, d16_eq, d16_lt} !== 3'b100 || d16_in_ready !== 1'b0)
                begin errors++; $display("FAIL bp_hold[%0d] got vld=%b res=%b rdy=%b exp vld=1 res=100 rdy=0",
                                         c, d16_out_valid, {d16_gt, d16_eq, d16_lt}, d16_in_ready); end
            d16_in_valid = (c == 1);
            d16_a = 16'h0000; d16_b = 16'hFFFF;
            @(posedge clk); #1;
        end
        d16_in_valid = 1'b0;
        checks++; if (d16_out_valid !== 1'b1 || {d16_gt, d16_eq, d16_lt} !== 3'b100)
            begin errors++; $display("FAIL bp_after_pulse got vld=%b res=%b exp vld=1 res=100", d16_out_valid, {d16_gt, d16_eq, d16_lt}); end
        d16_out_ready = 1'b1;
        @(posedge clk); #1;
        d16_out_ready = 1'b0;
        checks++; if (d16_out_valid !== 1'b0 || {d16_gt, d16_eq, d16_lt} !== 3'b000 || d16_in_ready !== 1'b1)
            begin errors++; $display("FAIL bp_release got vld=%b res=%b rdy=%b exp vld=0 res=000 rdy=1",
                                     d16_out_valid, {d16_gt, d16_eq, d16_lt}, d16_in_ready); end
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (d16_out_valid) seen = 1;
        end
        checks++; if (seen) begin errors++; $display("FAIL bp_no_accept got out_valid=1 exp 0 (pulse in DONE accepted)"); end
    endtask

    task automatic test_reset_mid_run();
        logic [2:0] res;
        int lat;
        d16_a = 16'h0005; d16_b = 16'h0003; d16_is_signed = 1'b0; d16_in_valid = 1'b1;
        @(posedge clk); #1;
        d16_in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (d16_out_valid !== 1'b0) begin errors++; $display("FAIL midrun_busy got out_valid=%b exp 0", d16_out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (d16_out_valid !== 1'b0 || {d16_gt, d16_eq, d16_lt} !== 3'b000 || d16_in_ready !== 1'b1)
            begin errors++; $display("FAIL midrun_reset got vld=%b res=%b rdy=%b exp vld=0 res=000 rdy=1",
                                     d16_out_valid, {d16_gt, d16_eq, d16_lt}, d16_in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (d16_in_ready !== 1'b1 || d16_out_valid !== 1'b0)
            begin errors++; $display("FAIL midrun_release got rdy=%b vld=%b exp rdy=1 vld=0", d16_in_ready, d16_out_valid); end
        run16(16'h0003, 16'h0005, 1'b0, res, lat);
        checks++; if (res !== 3'b001) begin errors++; $display("FAIL midrun_next_result got %b exp 001", res); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL midrun_next_latency got %0d exp 4", lat); end
    endtask

    task automatic test_random16();
        logic [15:0] a, b;
        logic s;
        logic [2:0] res, exp_res;
        int lat, exp_lat;
        for (int i = 0; i < 300; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            s = 1'($urandom);
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = a ^ (16'h1 << $urandom_range(0, 15));
                default: ;
            endcase
            exp_res = ref_cmp(16, a, b, s);
            exp_lat = ref_lat(16, 4, a, b);
            run16(a, b, s, res, lat);
            checks++; if (res !== exp_res) begin errors++; $display("FAIL rand16_result a=%h b=%h s=%b got %b exp %b", a, b, s, res, exp_res); end
            checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rand16_latency a=%h b=%h got %0d exp %0d", a, b, lat, exp_lat); end
        end
    endtask

    task automatic test_exhaustive4();
        logic [2:0] res, exp_res;
        int lat, exp_lat;
        for (int s = 0; s < 2; s++)
            for (int ia = 0; ia < 16; ia++)
                for (int ib = 0; ib < 16; ib++) begin
                    exp_res = ref_cmp(4, longint'(ia), longint'(ib), s[0]);
                    exp_lat = ref_lat(4, 1, longint'(ia), longint'(ib));
                    run4(4'(ia), 4'(ib), s[0], res, lat);
                    checks++; if (res !== exp_res || $countones(res) != 1)
                        begin errors++; $display("FAIL w4_result a=%0d b=%0d s=%0d got %b exp %b", ia, ib, s, res, exp_res); end
                    checks++; if (lat !== exp_lat)
                        begin errors++; $display("FAIL w4_latency a=%0d b=%0d got %0d exp %0d", ia, ib, lat, exp_lat); end
                end
    endtask

    task automatic test_sweep8();
        logic [7:0] corner [7] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};
        logic [7:0] a, b;
        logic [2:0] res, exp_res;
        int lat;
        for (int i = 0; i < 98 + 600; i++) begin
            if (i < 98) begin
                a = corner[(i / 14) % 7];
                b = corner[i % 7];
            end else begin
                a = 8'($urandom);
                b = 8'($urandom);
            end
            exp_res = ref_cmp(8, a, b, (i / 7) % 2 == 1);
            run8(a, b, (i / 7) % 2 == 1, res, lat);
            checks++; if (res !== exp_res || $countones(res) != 1)
                begin errors++; $display("FAIL w8_result a=%h b=%h s=%0d got %b exp %b", a, b, (i / 7) % 2, res, exp_res); end
            checks++; if (lat !== 1)
                begin errors++; $display("FAIL w8_latency a=%h b=%h got %0d exp 1", a, b, lat); end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired, simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        d16_in_valid = 0; d16_out_ready = 0; d16_a = 0; d16_b = 0; d16_is_signed = 0;
        d4_in_valid = 0;  d4_out_ready = 0;  d4_a = 0;  d4_b = 0;  d4_is_signed = 0;
        d8_in_valid = 0;  d8_out_ready = 0;  d8_a = 0;  d8_b = 0;  d8_is_signed = 0;
        #1;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_random16();
        test_exhaustive4();
        test_sweep8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seq_magnitude_comparator
`default_nettype wire
